// File: rtl/lpc_host_initiator.sv
// lpc_host_initiator: LPC host (initiator) that issues one single-byte read or
// write cycle per accepted command.  The START nibble picks TPM or plain I/O.
//
// Ports
//   clk_i, rst_i          LCLK and synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake (cmd_wr, cmd_addr, cmd_data)
//   resp_valid            one-cycle completion pulse with resp_data/resp_err
//   lframe_o, lad_o,      LPC pins driven by the host (LFRAME# active low,
//   lad_oe, lad_i         LAD output value, LAD output enable, LAD sampled)
//   dbg_state_o           current FSM state, for observation only
//
// Handshake: a command transfers on the rising edge where cmd_valid and
// cmd_ready are both high.  cmd_ready is high only in IDLE and never during
// reset.  cmd_* are latched on that edge and ignored otherwise.  resp_valid
// is a single-cycle pulse with no back-pressure; it appears in the first IDLE
// cycle, so a new command may be accepted in that same cycle.
module lpc_host_initiator #(
  parameter logic [3:0] START_NIBBLE = 4'b0101,
  parameter int         SYNC_TIMEOUT = 8,
  parameter int         LONG_TIMEOUT = 1000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_wr,
  input  logic [15:0] cmd_addr,
  input  logic [7:0]  cmd_data,
  output logic        resp_valid,
  output logic [7:0]  resp_data,
  output logic [1:0]  resp_err,
  output logic        lframe_o,
  output logic [3:0]  lad_o,
  output logic        lad_oe,
  input  logic [3:0]  lad_i,
  output logic [3:0]  dbg_state_o
);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_CYCDIR, S_ADDR, S_WDATA, S_HTAR,
    S_SYNC, S_RDATA, S_PTAR, S_ABORT, S_ABORT_END
  } state_e;

  localparam logic [15:0] SHORT_LIM = 16'(SYNC_TIMEOUT);
  localparam logic [15:0] LONG_LIM  = 16'(LONG_TIMEOUT);

  state_e      state_q, state_d;
  logic [1:0]  idx_q, idx_d;          // position inside multi-cycle states
  logic        wr_q, wr_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic [15:0] wcnt_q, wcnt_d;        // SYNC wait counter
  logic        long_q, long_d;        // long-wait seen in this SYNC phase
  logic        serr_q, serr_d;        // error SYNC received
  logic [7:0]  rdata_q, rdata_d;
  logic        resp_valid_q, resp_valid_d;
  logic [7:0]  resp_data_q, resp_data_d;
  logic [1:0]  resp_err_q, resp_err_d;
  logic        lframe_q, lframe_d;
  logic [3:0]  lad_o_q, lad_o_d;
  logic        lad_oe_q, lad_oe_d;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    data_d       = data_q;
    wcnt_d       = wcnt_q;
    long_d       = long_q;
    serr_d       = serr_q;
    rdata_d      = rdata_q;
    resp_valid_d = 1'b0;
    resp_data_d  = resp_data_q;
    resp_err_d   = resp_err_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          wr_d    = cmd_wr;
          addr_d  = cmd_addr;
          data_d  = cmd_data;
          state_d = S_START;
        end
      end
      S_START:  state_d = S_CYCDIR;
      S_CYCDIR: begin
        state_d = S_ADDR;
        idx_d   = 2'd0;
      end
      S_ADDR: begin
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          idx_d   = 2'd0;
          state_d = wr_q ? S_WDATA : S_HTAR;
        end
      end
      S_WDATA: begin
        idx_d = 2'd1;
        if (idx_q == 2'd1) begin
          idx_d   = 2'd0;
          state_d = S_HTAR;
        end
      end
      S_HTAR: begin
        idx_d = 2'd1;
        if (idx_q == 2'd1) begin
          idx_d   = 2'd0;
          wcnt_d  = 16'd0;
          long_d  = 1'b0;
          serr_d  = 1'b0;
          state_d = S_SYNC;
        end
      end
      S_SYNC: begin
        if (lad_i == 4'b0000 || lad_i == 4'b1010) begin
          serr_d  = (lad_i == 4'b1010);
          idx_d   = 2'd0;
          state_d = wr_q ? S_PTAR : S_RDATA;
        end else begin
          // Every non-terminal nibble counts; a long-wait nibble also
          // widens the limit, including for the nibble that carried it.
          wcnt_d = wcnt_q + 16'd1;
          if (lad_i == 4'b0110) long_d = 1'b1;
          if (wcnt_d >= (long_d ? LONG_LIM : SHORT_LIM)) begin
            idx_d   = 2'd0;
            state_d = S_ABORT;
          end
        end
      end
      S_RDATA: begin
        if (idx_q == 2'd0) begin
          rdata_d[3:0] = lad_i;
          idx_d        = 2'd1;
        end else begin
          rdata_d[7:4] = lad_i;
          idx_d        = 2'd0;
          state_d      = S_PTAR;
        end
      end
      S_PTAR: begin
        idx_d = 2'd1;
        if (idx_q == 2'd1) begin
          idx_d        = 2'd0;
          state_d      = S_IDLE;
          resp_valid_d = 1'b1;
          resp_data_d  = wr_q ? 8'h00 : rdata_q;
          resp_err_d   = {1'b0, serr_q};
        end
      end
      S_ABORT: begin
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          idx_d   = 2'd0;
          state_d = S_ABORT_END;
        end
      end
      S_ABORT_END: begin
        state_d      = S_IDLE;
        resp_valid_d = 1'b1;
        resp_data_d  = 8'h00;
        resp_err_d   = 2'b10;
      end
      default: state_d = S_IDLE;
    endcase

    // Pin values are decoded from the state being entered so that they are
    // registered alongside it.
    lframe_d = 1'b1;
    lad_oe_d = 1'b0;
    lad_o_d  = 4'hF;
    case (state_d)
      S_START: begin
        lframe_d = 1'b0;
        lad_oe_d = 1'b1;
        lad_o_d  = START_NIBBLE;
      end
      S_CYCDIR: begin
        lad_oe_d = 1'b1;
        lad_o_d  = wr_d ? 4'b0010 : 4'b0000;
      end
      S_ADDR: begin
        lad_oe_d = 1'b1;
        case (idx_d)
          2'd0:    lad_o_d = addr_d[15:12];
          2'd1:    lad_o_d = addr_d[11:8];
          2'd2:    lad_o_d = addr_d[7:4];
          default: lad_o_d = addr_d[3:0];
        endcase
      end
      S_WDATA: begin
        lad_oe_d = 1'b1;
        lad_o_d  = (idx_d == 2'd0) ? data_d[3:0] : data_d[7:4];
      end
      S_HTAR:  lad_oe_d = (idx_d == 2'd0);
      S_ABORT: begin
        lframe_d = 1'b0;
        lad_oe_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      idx_q        <= 2'd0;
      wr_q         <= 1'b0;
      addr_q       <= 16'h0000;
      data_q       <= 8'h00;
      wcnt_q       <= 16'd0;
      long_q       <= 1'b0;
      serr_q       <= 1'b0;
      rdata_q      <= 8'h00;
      resp_valid_q <= 1'b0;
      resp_data_q  <= 8'h00;
      resp_err_q   <= 2'b00;
      lframe_q     <= 1'b1;
      lad_o_q      <= 4'hF;
      lad_oe_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      wcnt_q       <= wcnt_d;
      long_q       <= long_d;
      serr_q       <= serr_d;
      rdata_q      <= rdata_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
      lframe_q     <= lframe_d;
      lad_o_q      <= lad_o_d;
      lad_oe_q     <= lad_oe_d;
    end
  end

  assign cmd_ready   = (state_q == S_IDLE) && !rst_i;
  assign resp_valid  = resp_valid_q;
  assign resp_data   = resp_data_q;
  assign resp_err    = resp_err_q;
  assign lframe_o    = lframe_q;
  assign lad_o       = lad_o_q;
  assign lad_oe      = lad_oe_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_lpc_host_initiator.sv
// Bench for lpc_host_initiator: directed and randomized LPC cycles against a
// peripheral emulation and a cycle-count model of the protocol.
module tb_lpc_host_initiator;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_i;
  logic        cmd_valid, cmd_ready, cmd_wr;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_data;
  logic        resp_valid;
  logic [7:0]  resp_data;
  logic [1:0]  resp_err;
  logic        lframe_o, lad_oe;
  logic [3:0]  lad_o, lad_i, dbg_state;

  always #5 clk = ~clk;

  lpc_host_initiator dut (
    .clk_i(clk), .rst_i(rst_i),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
    .lframe_o(lframe_o), .lad_o(lad_o), .lad_oe(lad_oe), .lad_i(lad_i),
    .dbg_state_o(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  typedef struct packed {
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [1:0]  err;
    logic [7:0]  rdata;
    logic [15:0] lat;   // cycle of resp_valid, counted from the accept edge
    logic [15:0] n;     // number of SYNC cycles
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  logic [3:0] sc [0:15];     // peripheral SYNC script; 1111 after its end
  int         sc_len;
  logic [3:0] drv [0:1199];  // nibbles the peripheral drives from first SYNC
  int         drv_len;
  logic [3:0] wl [0:6] = '{4'h5, 4'hF, 4'h6, 4'h1, 4'h3, 4'h7, 4'hC};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Walks the SYNC script by the protocol rules and derives the outcome,
  // the number of SYNC cycles and the completion cycle.
  task automatic build(input logic wr, input logic [15:0] addr,
                       input logic [7:0] wdata, input logic [3:0] rlo,
                       input logic [3:0] rhi, output exp_t e);
    int waits = 0, n = 0, res = -1, s;
    bit lng = 0;
    logic [3:0] nib;
    for (int k = 0; k < 1100 && res < 0; k++) begin
      nib = (k < sc_len) ? sc[k] : 4'hF;
      drv[k] = nib;
      n = k + 1;
      if (nib == 4'h0) res = 0;
      else if (nib == 4'hA) res = 1;
      else begin
        waits++;
        if (nib == 4'h6) lng = 1;
        if (waits >= (lng ? 1000 : 8)) res = 2;
      end
    end
    drv_len = n;
    if (!wr && res != 2) begin
      drv[n] = rlo;
      drv[n+1] = rhi;
      drv_len = n + 2;
    end
    s = wr ? 11 : 9;
    e.wr    = wr;
    e.addr  = addr;
    e.wdata = wdata;
    e.err   = 2'(res);
    e.rdata = (wr || res == 2) ? 8'h00 : {rhi, rlo};
    e.lat   = 16'((res == 2) ? s + n + 5 : s + n + (wr ? 0 : 2) + 2);
    e.n     = 16'(n);
  endtask

  function automatic logic [3:0] host_nib(input exp_t e, input int r);
    case (r)
      1: return 4'h5;
      2: return e.wr ? 4'h2 : 4'h0;
      3: return e.addr[15:12];
      4: return e.addr[11:8];
      5: return e.addr[7:4];
      6: return e.addr[3:0];
      7: return e.wr ? e.wdata[3:0] : 4'hF;
      8: return e.wr ? e.wdata[7:4] : 4'hF;
      default: return 4'hF;
    endcase
  endfunction

  // ---------------- monitor ----------------
  logic [3:0] tr_lad [0:2047];
  logic       tr_oe  [0:2047];
  logic       tr_lf  [0:2047];
  int         cyc = 0;
  int         acc_cyc = -100000;

  always @(negedge clk) begin
    int rel, hdr, ab_s;
    bit ab, win, e_lf, e_oe;
    exp_t e;
    cyc++;
    rel = cyc - acc_cyc;
    if (rel >= 0 && rel < 2048) begin
      tr_lad[rel] = lad_o;
      tr_oe[rel]  = lad_oe;
      tr_lf[rel]  = lframe_o;
    end
    if (resp_valid) begin
      chk("ready_in_resp_cycle", int'(cmd_ready), 1);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp actual=resp_valid expected=none @%0t", $time);
      end else begin
        e = exp_q.pop_front();
        chk("latency", rel, int'(e.lat));
        chk("resp_err", int'(resp_err), int'(e.err));
        chk("resp_data", int'(resp_data), int'(e.rdata));
        hdr  = e.wr ? 9 : 7;
        ab   = (e.err == 2'b10);
        ab_s = (e.wr ? 11 : 9) + int'(e.n);
        for (int r = 1; r < int'(e.lat) && r < 2048; r++) begin
          win  = ab && r >= ab_s && r < ab_s + 4;
          e_lf = !((r == 1) || win);
          e_oe = (r <= hdr) || win;
          chk($sformatf("lframe_c%0d", r), int'(tr_lf[r]), int'(e_lf));
          chk($sformatf("lad_oe_c%0d", r), int'(tr_oe[r]), int'(e_oe));
          if (e_oe)
            chk($sformatf("lad_o_c%0d", r), int'(tr_lad[r]),
                int'(win ? 4'hF : host_nib(e, r)));
        end
      end
    end
    if (cmd_valid && cmd_ready) acc_cyc = cyc;
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input exp_t e, input bit push, input bit keep);
    bit got = 0;
    if (push) exp_q.push_back(e);
    @(posedge clk); #1;
    cmd_wr = e.wr; cmd_addr = e.addr; cmd_data = e.wdata; cmd_valid = 1'b1;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (cmd_ready) got = 1;
    end
    if (!got) chk("accept_timeout", 0, 1);
    else begin
      @(posedge clk); #1;
    end
    if (!keep) cmd_valid = 1'b0;
  endtask

  // Peripheral: waits for the host to release LAD, then plays drv[] one
  // nibble per cycle starting with the first SYNC cycle.
  task automatic play();
    bit got = 0;
    lad_i = 4'hF;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (!lad_oe) got = 1;
    end
    if (!got) chk("lad_release_timeout", 0, 1);
    for (int i = 0; i < drv_len; i++) begin
      @(posedge clk); #1;
      lad_i = drv[i];
    end
    @(posedge clk); #1;
    lad_i = 4'hF;
    got = 0;
    for (int i = 0; i < 1200 && !got; i++) begin
      @(negedge clk);
      if (resp_valid) got = 1;
    end
    if (!got) chk("resp_timeout", 0, 1);
  endtask

  task automatic txn(input logic wr, input logic [15:0] addr,
                     input logic [7:0] wdata, input logic [3:0] rlo,
                     input logic [3:0] rhi);
    exp_t e;
    build(wr, addr, wdata, rlo, rhi, e);
    issue(e, 1'b1, 1'b0);
    play();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    exp_t e1, e2, er;
    int nw, mode;
    rst_i = 1'b1; cmd_valid = 1'b0; cmd_wr = 1'b0;
    cmd_addr = 16'h0; cmd_data = 8'h0; lad_i = 4'hF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_lframe", int'(lframe_o), 1);
    chk("rst_lad_oe", int'(lad_oe), 0);
    chk("rst_lad_o", int'(lad_o), 15);
    chk("rst_resp_valid", int'(resp_valid), 0);
    chk("rst_resp_data", int'(resp_data), 0);
    chk("rst_resp_err", int'(resp_err), 0);
    chk("rst_cmd_ready", int'(cmd_ready), 0);
    @(posedge clk); #1 rst_i = 1'b0;
    @(negedge clk);
    chk("idle_cmd_ready", int'(cmd_ready), 1);

    // Write 0x0F00 = 0xA5, ready SYNC.
    sc[0] = 4'h0; sc_len = 1;
    txn(1'b1, 16'h0F00, 8'hA5, 4'h0, 4'h0);
    // Read 0x0F18 with three short waits, data C,3 -> 0x3C.
    sc[0] = 4'h5; sc[1] = 4'h5; sc[2] = 4'h5; sc[3] = 4'h0; sc_len = 4;
    txn(1'b0, 16'h0F18, 8'h00, 4'hC, 4'h3);
    // Error SYNC then data F,E -> 0xEF, err 01.
    sc[0] = 4'hA; sc_len = 1;
    txn(1'b0, 16'h1234, 8'h00, 4'hF, 4'hE);
    // No response: timeout abort.
    sc_len = 0;
    txn(1'b0, 16'h00C0, 8'h00, 4'h0, 4'h0);
    // One long-wait nibble then silence: abort only after 1000 SYNC cycles.
    sc[0] = 4'h6; sc_len = 1;
    txn(1'b0, 16'h0F80, 8'h00, 4'h0, 4'h0);
    // Write timeout.
    sc_len = 0;
    txn(1'b1, 16'hBEEF, 8'h3C, 4'h0, 4'h0);

    // Reset during ADDR (cycle 4); no response may follow.
    er.wr = 1'b0; er.addr = 16'h5A5A; er.wdata = 8'h00;
    er.err = 2'b00; er.rdata = 8'h00; er.lat = 16'd0; er.n = 16'd0;
    issue(er, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("midrst_lframe", int'(lframe_o), 1);
    chk("midrst_lad_oe", int'(lad_oe), 0);
    chk("midrst_resp_valid", int'(resp_valid), 0);
    chk("midrst_resp_data", int'(resp_data), 0);
    @(posedge clk); #1 rst_i = 1'b0;
    @(negedge clk);
    chk("midrst_cmd_ready", int'(cmd_ready), 1);
    repeat (30) @(posedge clk);

    // Back-to-back with cmd_valid held high.
    sc[0] = 4'h5; sc[1] = 4'h0; sc_len = 2;
    build(1'b1, 16'h0F04, 8'h96, 4'h0, 4'h0, e1);
    issue(e1, 1'b1, 1'b1);
    cmd_wr = 1'b0; cmd_addr = 16'h0F24; cmd_data = 8'h00;
    play();
    chk("b2b_ready_in_resp", int'(cmd_ready), 1);
    sc[0] = 4'h0; sc_len = 1;
    build(1'b0, 16'h0F24, 8'h00, 4'h7, 4'h9, e2);
    exp_q.push_back(e2);
    @(posedge clk); #1 cmd_valid = 1'b0;
    @(negedge clk);
    chk("b2b_start_lframe", int'(lframe_o), 0);
    chk("b2b_start_lad", int'(lad_o), 5);
    play();

    // Randomized cycles.
    for (int t = 0; t < 24; t++) begin
      nw   = $urandom_range(0, 4);
      mode = $urandom_range(0, 9);
      for (int i = 0; i < nw; i++) begin
        sc[i] = wl[$urandom_range(0, 6)];
        if (mode == 9 && sc[i] == 4'h6) sc[i] = 4'hF;
      end
      sc_len = nw;
      if (mode < 6) begin sc[nw] = 4'h0; sc_len = nw + 1; end
      else if (mode < 9) begin sc[nw] = 4'hA; sc_len = nw + 1; end
      txn(1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom),
          4'($urandom), 4'($urandom));
    end

    repeat (5) @(posedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lpc_host_initiator.md
# lpc_host_initiator

Synthesizable LPC host that issues single-byte TPM-locality (or plain I/O) read and write cycles toward an LPC peripheral, i.e. the initiator end of the LAD/LFRAME protocol that `lpc_periph` answers. It serves as the bring-up and loopback driver for the TwPM FPGA, letting firmware or a test harness generate bus cycles without an external chipset. A simple command/response handshake sits on one side and the LPC pins on the other. Zero-wait SYNC handling, wait states, error SYNC and timeout-driven LPC abort are all covered.

## Interface
- `START_NIBBLE`, 4'b0101, START field value; 4'b0101 selects TPM cycles, 4'b0000 selects plain I/O.
- `SYNC_TIMEOUT`, 8, maximum SYNC cycles without ready/error/long-wait before abort.
- `LONG_TIMEOUT`, 1000, maximum SYNC cycles once any long-wait (0110) has been seen; must be <65536.
- `clk_i`  in  1  LPC clock (LCLK); all logic on rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  high only in IDLE and not in reset.
- `cmd_wr`  in  1  1 = write cycle, 0 = read cycle.
- `cmd_addr`  in  16  LPC address.
- `cmd_data`  in  8  write data, ignored for reads.
- `resp_valid`  out  1  one-cycle pulse at cycle completion.
- `resp_data`  out  8  read data; holds the last value; 8'h00 after writes and aborts.
- `resp_err`  out  2  00 ok, 01 peripheral error SYNC, 10 timeout/abort.
- `lframe_o`  out  1  LFRAME#, active low.
- `lad_o`  out  4  LAD drive value.
- `lad_oe`  out  4-bit bus enable (1 bit)  high while the host drives LAD.
- `lad_i`  in  4  LAD sampled value.

## Operation
- Reset values: `lframe_o`=1, `lad_oe`=0, `lad_o`=4'hF, `resp_valid`=0, `resp_data`=8'h00, `resp_err`=2'b00. State is IDLE.
- Command accept: the `cmd_*` fields are latched on the edge where `cmd_valid & cmd_ready` is true. Inputs are ignored at all other times.
- States: IDLE → START → CYCDIR → ADDR(4) → [WDATA(2) if write] → HTAR(2) → SYNC → [RDATA(2) if read] → PTAR(2) → IDLE. The path ABORT(4) → ABORT_END → IDLE is taken on timeout.
- START: `lframe_o`=0, `lad_o`=`START_NIBBLE`, `lad_oe`=1.
- CYCDIR: `lad_o`=4'b0000 for reads and 4'b0010 for writes. `lframe_o` returns to 1 here and stays high.
- ADDR: nibbles are driven MSB first, [15:12] through [3:0].
- WDATA: `cmd_data[3:0]` is driven first, then `cmd_data[7:4]`.
- HTAR: the first cycle drives `lad_o`=4'hF with `lad_oe`=1. The second cycle has `lad_oe`=0. `lad_oe` stays 0 from then until the next START.
- SYNC: `lad_i` is sampled every cycle.
  - 0000: leave SYNC with err=00.
  - 1010: leave SYNC with err=01.
  - 0101 (short wait), 1111, or any other value: stay in SYNC and increment the wait counter.
  - 0110 (long wait): stay in SYNC, increment the wait counter, and switch the limit to `LONG_TIMEOUT` for the rest of the cycle.
- Timeout: when the wait counter reaches the active limit, go to ABORT.
- RDATA: the low nibble is sampled first, then the high nibble, into `resp_data`. It runs after an error SYNC as well.
- PTAR: 2 cycles, host does not drive LAD, `lad_i` is ignored.
- ABORT: `lframe_o`=0, `lad_oe`=1, `lad_o`=4'hF for exactly 4 cycles.
- ABORT_END: `lframe_o`=1, `lad_oe`=0 for 1 cycle, then `resp_valid` with err=10.
- `resp_valid`: asserted for exactly 1 cycle, in the first IDLE cycle. `cmd_ready` is also high in that cycle, so back-to-back commands are allowed.
- Reset mid-cycle: on the next edge, all outputs take their reset values and the state goes to IDLE. No `resp_valid` is issued for the lost cycle.
- Wait counter: 16 bits, cleared on entry to SYNC.

## Timing
- Cycle numbering: cycle 0 is the accept edge, and cycle n is the n-th following clock period.
- Read with zero waits:
  - START in cycle 1, CYCDIR in 2, ADDR in 3–6.
  - HTAR in 7–8, SYNC in 9.
  - RDATA in 10–11, PTAR in 12–13.
  - `resp_valid` in cycle 14.
- Write with zero waits:
  - START in cycle 1, CYCDIR in 2, ADDR in 3–6.
  - WDATA in 7–8, HTAR in 9–10, SYNC in 11.
  - PTAR in 12–13.
  - `resp_valid` in cycle 14.
- Each non-terminal SYNC nibble adds exactly 1 cycle.
- Timeout with `SYNC_TIMEOUT`=8 and no response: SYNC occupies 8 cycles, then ABORT 4, ABORT_END 1, then `resp_valid`.
- `cmd_ready` is deasserted from cycle 1 until `resp_valid`.

## Test plan
- Write addr 0x0F00, data 0xA5, peripheral answers SYNC 0000:
  - LAD across cycles 1–10 must be 5,2,0,F,0,0,5,A,F,Z.
  - `lframe_o` must be low only in cycle 1.
  - `resp_valid` in cycle 14 with err=00.
- Read addr 0x0F18, peripheral returns SYNC 0101,0101,0101,0000 then nibbles C,3:
  - `resp_data`=0x3C, err=00, `resp_valid` in cycle 17.
- Read with SYNC 1010 followed by data nibbles F,E:
  - `resp_data`=0xEF, err=01, `resp_valid` in cycle 14.
- No peripheral response (LAD=1111):
  - after 8 SYNC cycles, `lframe_o` low with LAD=F for 4 cycles, then high.
  - `resp_valid` with err=10 in cycle 22.
  - Repeat with one 0110 nibble: no abort before 1000 SYNC cycles.
- Assert `rst_i` during ADDR cycle 4:
  - next cycle `lframe_o`=1, `lad_oe`=0, `cmd_ready`=1 after release.
  - no `resp_valid` ever issued for the interrupted cycle.
- Two back-to-back commands with `cmd_valid` held high:
  - the second is accepted in the `resp_valid` cycle.
  - its START appears in the next cycle.
